// File: rtl/dmem_hs_if.sv
// dmem_hs_if: request/response channel bundle between a load/store unit and dmem_hs.
//   master modport: drives the request channel and resp_ready (the CPU side).
//   slave  modport: drives req_ready and the response channel (the memory side).
// Signals:
//   req_valid/req_ready        request handshake
//   req_write/addr/wdata/size  store flag, byte address, right-aligned store data, access size
//   req_unsigned               load zero-extend (1) / sign-extend (0)
//   resp_valid/resp_ready      response handshake
//   resp_rdata/resp_err        extended load data (0 for stores/errors), error flag
interface dmem_hs_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_hs.sv
// dmem_hs: handshaked word-organised data RAM with byte/half/word access, sign/zero
// extension, LATENCY wait cycles between accept and response, and error reporting for
// misaligned, illegal-size and out-of-range accesses.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset (RAM contents are kept)
//   bus  dmem_hs_if.slave: request channel in, response channel out
module dmem_hs #(
   parameter int unsigned  DEPTH   = 256,
   parameter int unsigned  LATENCY = 1,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input logic      clk,
   input logic      rst,
   dmem_hs_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   localparam logic [3:0] CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        commit;

   logic        wr_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        uns_q;

   logic        cur_write;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [1:0]  cur_size;
   logic        cur_uns;

   logic          err;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word, lane, ld;
   logic [3:0]    be;
   logic [31:0]   wd;

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;
   logic        err_q;

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = (state_q == StResp);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // With zero latency the commit edge is the accept edge, so the live request must be used;
   // otherwise the latched copy is used and the inputs are ignored after accept.
   always_comb begin
      if (state_q == StIdle) begin
         cur_write = bus.req_write;
         cur_addr  = bus.req_addr;
         cur_wdata = bus.req_wdata;
         cur_size  = bus.req_size;
         cur_uns   = bus.req_unsigned;
      end else begin
         cur_write = wr_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_size  = size_q;
         cur_uns   = uns_q;
      end
   end

   // DEPTH is a power of two, so any set bit above the word index is out of range.
   assign err = (cur_size == 2'b11)
              | ((cur_size == 2'b01) & cur_addr[0])
              | ((cur_size == 2'b10) & (cur_addr[1:0] != 2'b00))
              | (|cur_addr[31:AW+2]);

   assign idx     = cur_addr[AW+1:2];
   assign rd_word = mem[idx];
   // Aligned accesses only reach here without error, so one shift serves byte and half.
   assign lane    = rd_word >> {cur_addr[1:0], 3'b000};

   always_comb begin
      ld = rd_word;
      be = 4'b1111;
      wd = cur_wdata;
      case (cur_size)
         2'b00: begin
            ld = {{24{~cur_uns & lane[7]}}, lane[7:0]};
            be = 4'b0001 << cur_addr[1:0];
            wd = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            ld = {{16{~cur_uns & lane[15]}}, lane[15:0]};
            be = cur_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{cur_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (LATENCY == 0) begin
                  state_d = StResp;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntInit;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (bus.resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            rdata_q <= (err | cur_write) ? 32'd0 : ld;
            err_q   <= err;
         end else if ((state_q == StResp) && bus.resp_ready) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == StIdle) && bus.req_valid) begin
         wr_q    <= bus.req_write;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         size_q  <= bus.req_size;
         uns_q   <= bus.req_unsigned;
      end
   end

   // Gated by rst so a request aborted by reset never reaches the array.
   always_ff @(posedge clk) begin
      if (!rst && commit && cur_write && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: directed and model-checked bench for dmem_hs, one instance with LATENCY=0
// and one with LATENCY=3, sharing the bench-side request signals.
module tb_dmem_hs;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        sel = 1'b0;  // 0: zero-latency instance, 1: LATENCY=3 instance
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic        resp_ready = 1'b0;

   dmem_hs_if if0 ();
   dmem_hs_if if3 ();

   assign if0.req_valid    = req_valid & ~sel;
   assign if3.req_valid    = req_valid & sel;
   assign if0.resp_ready   = resp_ready & ~sel;
   assign if3.resp_ready   = resp_ready & sel;
   assign if0.req_write    = req_write;
   assign if3.req_write    = req_write;
   assign if0.req_addr     = req_addr;
   assign if3.req_addr     = req_addr;
   assign if0.req_wdata    = req_wdata;
   assign if3.req_wdata    = req_wdata;
   assign if0.req_size     = req_size;
   assign if3.req_size     = req_size;
   assign if0.req_unsigned = req_unsigned;
   assign if3.req_unsigned = req_unsigned;

   dmem_hs #(.DEPTH(256), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   dmem_hs #(.DEPTH(256), .LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

   wire        rv    = sel ? if3.resp_valid : if0.resp_valid;
   wire        rrdy  = sel ? if3.req_ready  : if0.req_ready;
   wire [31:0] rdata = sel ? if3.resp_rdata : if0.resp_rdata;
   wire        rerr  = sel ? if3.resp_err   : if0.resp_err;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction; hold = cycles of resp_ready=0 after resp_valid rises.
   // lat = cycles from the accept cycle to the first cycle with resp_valid high.
   task automatic access(input logic s, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz, input logic u,
                         input int hold, output logic [31:0] rd, output logic er,
                         output int lat);
      int n;
      logic ok;
      logic [31:0] rd0;
      logic er0;
      sel = s; req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
      req_valid = 1'b1;
      n = 0;
      while (!rrdy && n < 20) begin @(posedge clk); #1; n++; end
      check("req_ready_wait", 32'(rrdy), 32'd1);
      @(posedge clk); #1;
      // Scramble inputs: the DUT must work from its latched copy.
      req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF; req_wdata = ~d;
      req_size = 2'b11; req_unsigned = ~u;
      lat = 1; ok = 1'b1;
      while (!rv && lat < 40) begin
         if (rrdy) ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      check("resp_valid_wait", 32'(rv), 32'd1);
      rd0 = rdata; er0 = rerr;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (!rv || rdata !== rd0 || rerr !== er0 || rrdy) ok = 1'b0;
      end
      check("busy_hold_stable", 32'(ok), 32'd1);
      resp_ready = 1'b1;
      rd = rdata; er = rerr;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("post_hs_valid", 32'(rv), 32'd0);
      check("post_hs_rdata", rdata, 32'd0);
      check("post_hs_err", 32'(rerr), 32'd0);
      check("post_hs_ready", 32'(rrdy), 32'd1);
   endtask

   function automatic logic m_err(logic [31:0] a, logic [1:0] sz);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
             || (a >= 32'd1024);
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] wv, logic [31:0] a, logic [1:0] sz,
                                          logic u);
      logic [7:0]  b;
      logic [15:0] h;
      b = wv[8*a[1:0] +: 8];
      h = a[1] ? wv[31:16] : wv[15:0];
      if (sz == 2'b00) return u ? {24'd0, b} : {{24{b[7]}}, b};
      if (sz == 2'b01) return u ? {16'd0, h} : {{16{h[15]}}, h};
      return wv;
   endfunction

   function automatic logic [31:0] m_store(logic [31:0] wv, logic [31:0] a, logic [1:0] sz,
                                           logic [31:0] d);
      logic [31:0] r;
      r = wv;
      if (sz == 2'b00) r[8*a[1:0] +: 8] = d[7:0];
      else if (sz == 2'b01) r[16*a[1] +: 16] = d[15:0];
      else r = d;
      return r;
   endfunction

   logic [31:0] ref_m [2][16];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic er;
      int lat;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sel = 1'b0;
      check("rst0_ready", 32'(if0.req_ready), 32'd1);
      check("rst0_valid", 32'(if0.resp_valid), 32'd0);
      check("rst0_rdata", if0.resp_rdata, 32'd0);
      check("rst0_err", 32'(if0.resp_err), 32'd0);
      check("rst3_ready", 32'(if3.req_ready), 32'd1);
      check("rst3_valid", 32'(if3.resp_valid), 32'd0);

      // Zero latency word store/load
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, er, lat);
      check("l0_st_lat", 32'(lat), 32'd1);
      check("l0_st_err", 32'(er), 32'd0);
      check("l0_st_rdata", rd, 32'd0);
      access(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1, rd, er, lat);
      check("l0_ld_lat", 32'(lat), 32'd1);
      check("l0_ld_word", rd, 32'hDEADBEEF);
      check("l0_ld_err", 32'(er), 32'd0);

      // Extension
      access(1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd, er, lat);
      check("ld_b13_s", rd, 32'hFFFFFFDE);
      access(1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd, er, lat);
      check("ld_b13_u", rd, 32'h000000DE);
      access(1'b0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 0, rd, er, lat);
      check("ld_h12_s", rd, 32'hFFFFDEAD);
      access(1'b0, 1'b1, 32'h11, 32'hFFFFFF55, 2'b00, 1'b0, 0, rd, er, lat);
      access(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      check("ld_after_sb", rd, 32'hDEAD55EF);
      access(1'b0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 0, rd, er, lat);
      check("ld_h10_u", rd, 32'h000055EF);
      access(1'b0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 0, rd, er, lat);
      check("ld_b10_s", rd, 32'hFFFFFFEF);
      access(1'b0, 1'b1, 32'h14, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      access(1'b0, 1'b1, 32'h16, 32'h7777ABCD, 2'b01, 1'b0, 0, rd, er, lat);
      access(1'b0, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      check("ld_after_sh", rd, 32'hABCD0000);

      // Errors
      access(1'b0, 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0, rd, er, lat);
      check("err_h11", {31'd0, er}, 32'd1);
      check("err_h11_rd", rd, 32'd0);
      access(1'b0, 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      check("err_w12", {31'd0, er}, 32'd1);
      access(1'b0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, rd, er, lat);
      check("err_sz11", {31'd0, er}, 32'd1);
      check("err_sz11_rd", rd, 32'd0);
      access(1'b0, 1'b0, 32'd1024, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      check("err_range", {31'd0, er}, 32'd1);
      access(1'b0, 1'b1, 32'h410, 32'h11111111, 2'b10, 1'b0, 0, rd, er, lat);
      check("err_range_st", {31'd0, er}, 32'd1);
      access(1'b0, 1'b1, 32'h12, 32'h22222222, 2'b10, 1'b0, 0, rd, er, lat);
      check("err_mis_st", {31'd0, er}, 32'd1);
      access(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      check("err_ram_kept", rd, 32'hDEAD55EF);
      check("err_ram_kept_e", {31'd0, er}, 32'd0);

      // LATENCY=3 with backpressure
      access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, 5, rd, er, lat);
      check("l3_st_lat", 32'(lat), 32'd4);
      access(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 5, rd, er, lat);
      check("l3_ld_lat", 32'(lat), 32'd4);
      check("l3_ld_data", rd, 32'hCAFEF00D);
      access(1'b1, 1'b0, 32'h42, 32'h0, 2'b10, 1'b0, 5, rd, er, lat);
      check("l3_err", {31'd0, er}, 32'd1);

      // Reset while waiting on a store
      access(1'b1, 1'b1, 32'h20, 32'h0BADF00D, 2'b10, 1'b0, 0, rd, er, lat);
      sel = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("mid_in_wait", 32'(if3.req_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_ready", 32'(if3.req_ready), 32'd1);
      check("mid_rst_valid", 32'(if3.resp_valid), 32'd0);
      check("mid_rst_rdata", if3.resp_rdata, 32'd0);
      check("mid_rst_err", 32'(if3.resp_err), 32'd0);
      repeat (5) @(posedge clk);
      #1 check("mid_no_resp", 32'(if3.resp_valid), 32'd0);
      access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      check("mid_ram_kept", rd, 32'h0BADF00D);
      access(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
      check("rst_keeps_ram0", rd, 32'hDEAD55EF);

      // Random accesses against a reference model on 16 words at 0x100
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) begin
            ref_m[s][i] = $urandom;
            access(s[0], 1'b1, 32'h100 + 32'(4*i), ref_m[s][i], 2'b10, 1'b0, 0, rd, er, lat);
         end
         for (int k = 0; k < 30; k++) begin
            logic        w, u, ee;
            logic [1:0]  sz;
            logic [31:0] a, d, ex;
            int          wi;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            wi = $urandom_range(0, 15);
            a  = 32'h100 + 32'(4*wi) + 32'($urandom_range(0, 3));
            d  = $urandom;
            ee = m_err(a, sz);
            ex = (ee || w) ? 32'd0 : m_load(ref_m[s][wi], a, sz, u);
            if (w && !ee) ref_m[s][wi] = m_store(ref_m[s][wi], a, sz, d);
            access(s[0], w, a, d, sz, u, $urandom_range(0, 2), rd, er, lat);
            check("rnd_rdata", rd, ex);
            check("rnd_err", {31'd0, er}, {31'd0, ee});
            check("rnd_lat", 32'(lat), (s == 0) ? 32'd1 : 32'd4);
         end
         for (int i = 0; i < 16; i++) begin
            access(s[0], 1'b0, 32'h100 + 32'(4*i), 32'h0, 2'b10, 1'b0, 0, rd, er, lat);
            check("rnd_final", rd, ref_m[s][i]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
